// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8N1 UART receiver gated by the debug enable
//
// Frames 8N1 characters from an asynchronous line. Each good byte is presented
// on rx_Data with a one-cycle Rx_done strobe; a low stop bit gives a one-cycle
// frame_err_o strobe and parks the receiver until the line returns high.

module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       debug_en_i,
  input  logic       rx_i,
  output logic       Rx_done,
  output logic [7:0] rx_Data,
  output logic       frame_err_o,
  output logic       busy_o
);

  // Clocks per bit and the half-bit offset used to land samples mid-bit.
  localparam int CPB  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);

  localparam logic [CW-1:0] CNT_BIT_END  = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_d;
  logic            done_d;
  logic            err_d;

  logic            sync_q1, sync_q2;
  logic            rxs;

  // Two-flop synchronizer on the raw line; resets to the idle (high) level so
  // reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= rx_i;
      sync_q2 <= sync_q1;
    end
  end

  assign rxs = sync_q2;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, bit timing and byte assembly; the enable overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = rx_Data;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (!debug_en_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (!rxs) begin
            state_d = S_START;
          end
        end

        // Re-check the start bit half a bit in; a short glitch goes back idle.
        S_START: begin
          if (cnt_q == CNT_HALF_END) begin
            cnt_d = '0;
            if (!rxs) begin
              state_d = S_DATA;
              idx_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        // One sample per bit period, LSB first.
        S_DATA: begin
          if (cnt_q == CNT_BIT_END) begin
            cnt_d          = '0;
            shift_d[idx_q] = rxs;
            if (idx_q == 3'd7) begin
              idx_d   = '0;
              state_d = S_STOP;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        // Only a high stop bit publishes the byte; returning to IDLE right at
        // the stop sample leaves half a bit of slack for the next start edge.
        S_STOP: begin
          if (cnt_q == CNT_BIT_END) begin
            cnt_d = '0;
            if (rxs) begin
              data_d  = shift_q;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        // A held-low line must not look like an endless stream of start bits.
        S_BREAK: begin
          cnt_d = '0;
          if (rxs) begin
            state_d = S_IDLE;
          end
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Datapath registers and registered strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      rx_Data     <= '0;
      Rx_done     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_Data     <= data_d;
      Rx_done     <= done_d;
      frame_err_o <= err_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx at 16 clocks per bit

module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       debug_en_i;
  logic       rx_i;
  logic       Rx_done;
  logic [7:0] rx_Data;
  logic       frame_err_o;
  logic       busy_o;

  uart_rx #(
    .CLK_FREQ (1_600_000),
    .BAUD_RATE(100_000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .debug_en_i (debug_en_i),
    .rx_i       (rx_i),
    .Rx_done    (Rx_done),
    .rx_Data    (rx_Data),
    .frame_err_o(frame_err_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  // Rising-edge count; a value seen at a negedge names the edge just before it.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected strobe events: stop-sample edge number, kind, byte.
  typedef struct {
    int         cyc;
    logic       err;
    logic [7:0] data;
  } ev_t;

  ev_t        evq[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_data;
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         last_done_cyc = 0;
  int         last_t0 = 0;
  logic [7:0] log_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison of the strobes and held byte against the event model.
  task automatic compare_loop();
    logic exp_done, exp_err;
    ev_t  e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_data = 8'h00;
        evq.delete();
        chk("rst_rx_data", {24'd0, rx_Data}, 32'd0);
      end else begin
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (evq.size() > 0 && evq[0].cyc == cyc) begin
          e = evq.pop_front();
          if (e.err) begin
            exp_err = 1'b1;
          end else begin
            exp_done = 1'b1;
            exp_data = e.data;
          end
        end
        chk("rx_done", {31'd0, Rx_done}, {31'd0, exp_done});
        chk("frame_err", {31'd0, frame_err_o}, {31'd0, exp_err});
        chk("rx_data", {24'd0, rx_Data}, {24'd0, exp_data});
        if (Rx_done) begin
          done_cnt++;
          last_done_cyc = cyc;
          log_q.push_back(rx_Data);
        end
        if (frame_err_o) err_cnt++;
      end
    end
  endtask

  // Drive one 8N1 frame. mode 0: expected frame; 1: drop enable mid data bit k;
  // 2: assert reset mid data bit k; 3: frame not expected to be received.
  task automatic send(input logic [7:0] b, input logic stop, input int mode, input int k);
    ev_t e;
    last_t0 = cyc + 1;
    if (mode == 0) begin
      e.cyc  = last_t0 + 2 + HALF + 9 * CPB;
      e.err  = ~stop;
      e.data = b;
      evq.push_back(e);
    end
    rx_i = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      if (i == k && (mode == 1 || mode == 2)) begin
        repeat (HALF) tick();
        if (mode == 1) begin
          debug_en_i = 1'b0;
        end else begin
          chk("busy_before_rst", {31'd0, busy_o}, 32'd1);
          rst = 1'b0;
          evq.delete();
          #1;
          chk("async_rst_data", {24'd0, rx_Data}, 32'd0);
          chk("async_rst_done", {31'd0, Rx_done}, 32'd0);
          chk("async_rst_err", {31'd0, frame_err_o}, 32'd0);
          chk("async_rst_busy", {31'd0, busy_o}, 32'd0);
        end
        repeat (CPB - HALF) tick();
      end else begin
        repeat (CPB) tick();
      end
    end
    rx_i = stop;
    repeat (CPB) tick();
  endtask

  initial begin
    rst        = 1'b0;
    debug_en_i = 1'b1;
    rx_i       = 1'b1;
    fork
      compare_loop();
    join_none

    repeat (3) tick();
    chk("reset_done", {31'd0, Rx_done}, 32'd0);
    chk("reset_data", {24'd0, rx_Data}, 32'd0);
    chk("reset_err", {31'd0, frame_err_o}, 32'd0);
    chk("reset_busy", {31'd0, busy_o}, 32'd0);
    rst = 1'b1;
    repeat (2 * CPB) tick();

    // Single byte: strobe follows edge t0+154.
    send(8'hA5, 1'b1, 0, 0);
    repeat (CPB) tick();
    chk("a5_latency", last_done_cyc - last_t0, 32'd154);
    chk("a5_count", done_cnt, 32'd1);
    chk("a5_byte", {24'd0, log_q[0]}, 32'h0000_00A5);
    chk("a5_no_err", err_cnt, 32'd0);

    // Back-to-back frames, one stop bit each.
    send(8'h00, 1'b1, 0, 0);
    send(8'hFF, 1'b1, 0, 0);
    send(8'h3C, 1'b1, 0, 0);
    send(8'h12, 1'b1, 0, 0);
    repeat (CPB) tick();
    chk("b2b_count", done_cnt, 32'd5);
    chk("b2b_byte0", {24'd0, log_q[1]}, 32'h0000_0000);
    chk("b2b_byte1", {24'd0, log_q[2]}, 32'h0000_00FF);
    chk("b2b_byte2", {24'd0, log_q[3]}, 32'h0000_003C);
    chk("b2b_byte3", {24'd0, log_q[4]}, 32'h0000_0012);

    // Three-cycle glitch: busy from t0+2, back idle at the start sample.
    rx_i = 1'b0;
    repeat (3) tick();
    rx_i = 1'b1;
    chk("glitch_busy_on", {31'd0, busy_o}, 32'd1);
    repeat (HALF) tick();
    chk("glitch_busy_off", {31'd0, busy_o}, 32'd0);
    repeat (2 * CPB) tick();
    chk("glitch_no_done", done_cnt, 32'd5);
    chk("glitch_no_err", err_cnt, 32'd0);

    // Low stop bit, then a 40-bit break, release, then a good byte.
    send(8'h55, 1'b0, 0, 0);
    repeat (40 * CPB) tick();
    chk("break_busy", {31'd0, busy_o}, 32'd1);
    chk("break_err_once", err_cnt, 32'd1);
    chk("break_no_done", done_cnt, 32'd5);
    rx_i = 1'b1;
    repeat (2 * CPB) tick();
    chk("break_released", {31'd0, busy_o}, 32'd0);
    send(8'h81, 1'b1, 0, 0);
    repeat (CPB) tick();
    chk("after_break_count", done_cnt, 32'd6);
    chk("after_break_byte", {24'd0, log_q[5]}, 32'h0000_0081);

    // Enable dropped at data bit 3, then a good frame, then a disabled frame.
    send(8'hC3, 1'b1, 1, 3);
    repeat (2) tick();
    debug_en_i = 1'b1;
    repeat (2 * CPB) tick();
    send(8'h7E, 1'b1, 0, 0);
    repeat (CPB) tick();
    chk("abort_count", done_cnt, 32'd7);
    chk("abort_byte", {24'd0, log_q[6]}, 32'h0000_007E);
    debug_en_i = 1'b0;
    send(8'h5A, 1'b1, 3, 0);
    repeat (CPB) tick();
    debug_en_i = 1'b1;
    repeat (2 * CPB) tick();
    chk("disabled_count", done_cnt, 32'd7);
    chk("disabled_err", err_cnt, 32'd1);

    // Reset during data bit 5, then a full frame.
    send(8'h66, 1'b1, 2, 5);
    rst = 1'b1;
    repeat (2 * CPB) tick();
    send(8'h99, 1'b1, 0, 0);
    repeat (CPB) tick();
    chk("post_rst_count", done_cnt, 32'd8);
    chk("post_rst_byte", {24'd0, log_q[7]}, 32'h0000_0099);
    chk("final_err_count", err_cnt, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
